// File: rtl/board_mem_pkg.sv
// Shared constants for the board-memory subsystem: RAM geometry, channel
// indices of the game-logic requesters, and the arbiter state encoding.
package board_mem_pkg;

    localparam int MEM_ADDR_W   = 7;
    localparam int MEM_DATA_W   = 2;
    localparam int NUM_BOARD_CH = 4;

    // Fixed channel assignment on the board RAM port.
    localparam int CH_INIT = 0;
    localparam int CH_VALI = 1;
    localparam int CH_FLIP = 2;
    localparam int CH_VGA  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/board_mem_arbiter_rr_pick.sv
// Winner selection for the board-memory arbiter: lowest set index, or the
// first set index strictly after a base index (with wrap) in round-robin mode.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req_vec,
    input  logic [IDX_W-1:0]  base,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] winner,
    output logic              any_valid
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        winner    = '0;
        any_valid = |req_vec;
        idx       = 0;
        if (rr_mode) begin
            // Walk from the farthest offset down so the nearest one after base wins.
            for (int off = NUM_CH; off >= 1; off--) begin
                idx = (int'(base) + off) % NUM_CH;
                if (req_vec[IDX_W'(idx)]) begin
                    winner             = '0;
                    winner[IDX_W'(idx)] = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req_vec[i]) begin
                    winner    = '0;
                    winner[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Registered request/grant arbiter sharing the single-port board RAM among
// NUM_CH engines, with bounded hold time, lock override and tagged read return.
module board_mem_arbiter
    import board_mem_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = board_mem_pkg::MEM_ADDR_W,
    parameter int DATA_W   = board_mem_pkg::MEM_DATA_W,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        lock,
    input  logic [NUM_CH*ADDR_W-1:0] addr_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        wren_in,
    input  logic [DATA_W-1:0]        mem_q,
    output logic [NUM_CH-1:0]        gnt,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     wren_out,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        rvalid,
    output logic                     busy
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_CH - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] rvalid_q;

    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;

    // The owner is never a candidate: on release its req is already low, and
    // on preemption the grant must pass to someone else.
    assign cand = (state_q == ST_OWNED) ? (req & ~gnt_q) : req;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req_vec   (cand),
        .base      (last_q),
        .rr_mode   (RR_MODE != 0),
        .winner    (win_oh),
        .any_valid (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_oh[i]) win_idx = IDX_W'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_OWNED;
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    hold_d  = HOLD_W'(1);
                end
            end

            ST_OWNED: begin
                if (!req[owner_q]) begin
                    // Release hands straight to the next winner, no dead cycle.
                    if (win_any) begin
                        gnt_d   = win_oh;
                        owner_d = win_idx;
                        last_d  = win_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if ((hold_q == HOLD_MAX) && !lock[owner_q] && win_any) begin
                    gnt_d   = win_oh;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    hold_d  = HOLD_W'(1);
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // A granted, requesting, non-writing cycle is a read; its data returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt_q & req & ~wren_in;
        end
    end

    // Bus mux driven from registered owner/grant so an async reset kills it at once.
    always_comb begin
        addr_out = '0;
        data_out = '0;
        wren_out = 1'b0;
        if (|gnt_q) begin
            addr_out = addr_in[int'(owner_q)*ADDR_W +: ADDR_W];
            data_out = data_in[int'(owner_q)*DATA_W +: DATA_W];
            wren_out = wren_in[owner_q] & req[owner_q] & gnt_q[owner_q];
        end
    end

    assign gnt    = gnt_q;
    assign busy   = |gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = mem_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter: a fixed-priority instance (MAX_HOLD=4)
// with a RAM model and a round-robin instance driven by the same inputs.
module tb_board_mem_arbiter;
    import board_mem_pkg::*;

    localparam int NUM_CH = NUM_BOARD_CH;
    localparam int ADDR_W = MEM_ADDR_W;
    localparam int DATA_W = MEM_DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        lock;
    logic [NUM_CH-1:0]        wren_in;
    logic [NUM_CH*ADDR_W-1:0] addr_in;
    logic [NUM_CH*DATA_W-1:0] data_in;

    logic [NUM_CH-1:0] gnt0, rvalid0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0, rdata0, mem_q0;
    logic              wren0, busy0;

    logic [NUM_CH-1:0] gnt1, rvalid1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1, rdata1, mem_q1;
    logic              wren1, busy1;

    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(0), .MAX_HOLD(4)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr_in(addr_in),
        .data_in(data_in), .wren_in(wren_in), .mem_q(mem_q0), .gnt(gnt0),
        .addr_out(addr0), .data_out(data0), .wren_out(wren0), .rdata(rdata0),
        .rvalid(rvalid0), .busy(busy0)
    );

    board_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_MODE(1), .MAX_HOLD(16)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .addr_in(addr_in),
        .data_in(data_in), .wren_in(wren_in), .mem_q(mem_q1), .gnt(gnt1),
        .addr_out(addr1), .data_out(data1), .wren_out(wren1), .rdata(rdata1),
        .rvalid(rvalid1), .busy(busy1)
    );

    assign mem_q1 = '0;

    // Synchronous single-port RAM: read-before-write, data one cycle after address.
    always @(posedge clk) begin
        if (wren0) mem0[addr0] <= data0;
        mem_q0 <= mem0[addr0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        lock    = '0;
        wren_in = '0;
        rst_n   = 1'b0;
        step();
        rst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lost;
        req     = '0;
        lock    = '0;
        wren_in = '0;
        addr_in = '0;
        data_in = '0;
        addr_in[0*ADDR_W +: ADDR_W] = 7'h10;
        addr_in[1*ADDR_W +: ADDR_W] = 7'h21;
        addr_in[2*ADDR_W +: ADDR_W] = 7'h32;
        addr_in[3*ADDR_W +: ADDR_W] = 7'h25;
        data_in[1*DATA_W +: DATA_W] = 2'b10;

        // Reset state
        step();
        check("rst_gnt",    32'(gnt0),    32'h0);
        check("rst_busy",   32'(busy0),   32'h0);
        check("rst_addr",   32'(addr0),   32'h0);
        check("rst_wren",   32'(wren0),   32'h0);
        check("rst_rvalid", 32'(rvalid0), 32'h0);
        check("rst_gnt_rr", 32'(gnt1),    32'h0);
        rst_n = 1'b1;

        // Fixed priority: req 1010 -> ch1, bus follows ch1
        req     = 4'b1010;
        wren_in = 4'b1010;
        #1;
        check("idle_wren", 32'(wren0), 32'h0);
        check("idle_addr", 32'(addr0), 32'h0);
        step();
        check("fp_gnt",    32'(gnt0),  32'h2);
        check("fp_addr",   32'(addr0), 32'h21);
        check("fp_data",   32'(data0), 32'h2);
        check("fp_wren",   32'(wren0), 32'h1);
        check("fp_busy",   32'(busy0), 32'h1);
        check("rr_first",  32'(gnt1),  32'h2);

        // Round-robin: all request, each owner releases after one cycle
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req = (k == 0) ? 4'b1111 : ~(4'b0001 << ((k - 1) % 4));
            step();
            check("rr_order", 32'(gnt1), 32'(1 << (k % 4)));
        end

        // Preemption after MAX_HOLD=4 granted cycles
        do_reset();
        req = 4'b0100;
        step();
        check("pre_first", 32'(gnt0), 32'h4);
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pre_hold", 32'(gnt0), 32'h4);
        end
        step();
        check("pre_move", 32'(gnt0), 32'h1);

        // Lock inhibits preemption
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        req  = 4'b0101;
        lost = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (gnt0 !== 4'b0100) lost++;
        end
        check("lock_hold", 32'(lost), 32'h0);
        lock = '0;
        step();
        check("lock_drop", 32'(gnt0), 32'h1);

        // ch3 writes 0x25/0x26 then reads both back-to-back
        do_reset();
        addr_in[3*ADDR_W +: ADDR_W] = 7'h25;
        data_in[3*DATA_W +: DATA_W] = 2'b11;
        wren_in = 4'b1000;
        req     = 4'b1000;
        step();
        check("wr_gnt",  32'(gnt0),  32'h8);
        check("wr_wren", 32'(wren0), 32'h1);
        step();
        check("wr_rvalid", 32'(rvalid0), 32'h0);
        addr_in[3*ADDR_W +: ADDR_W] = 7'h26;
        data_in[3*DATA_W +: DATA_W] = 2'b01;
        step();
        wren_in = '0;
        addr_in[3*ADDR_W +: ADDR_W] = 7'h25;
        step();
        check("rd1_rvalid", 32'(rvalid0), 32'h8);
        check("rd1_rdata",  32'(rdata0),  32'h3);
        addr_in[3*ADDR_W +: ADDR_W] = 7'h26;
        step();
        check("rd2_rvalid", 32'(rvalid0), 32'h8);
        check("rd2_rdata",  32'(rdata0),  32'h1);
        req = '0;
        step();
        check("rd_end_rvalid", 32'(rvalid0), 32'h0);
        check("rd_end_gnt",    32'(gnt0),    32'h0);

        // Handoff ch1 -> ch3 without an idle cycle
        do_reset();
        req = 4'b0010;
        step();
        check("ho_first", 32'(gnt0), 32'h2);
        req = 4'b1000;
        step();
        check("ho_next", 32'(gnt0),  32'h8);
        check("ho_busy", 32'(busy0), 32'h1);

        // Async reset mid-write with a read return pending
        do_reset();
        req = 4'b0100;
        step();
        step();
        check("ar_rvalid_pre", 32'(rvalid0), 32'h4);
        wren_in = 4'b0100;
        #1;
        check("ar_wren_pre", 32'(wren0), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_wren",   32'(wren0),   32'h0);
        check("ar_gnt",    32'(gnt0),    32'h0);
        check("ar_busy",   32'(busy0),   32'h0);
        check("ar_addr",   32'(addr0),   32'h0);
        check("ar_rvalid", 32'(rvalid0), 32'h0);
        check("ar_gnt_rr", 32'(gnt1),    32'h0);
        req     = 4'b1111;
        wren_in = '0;
        #1;
        rst_n = 1'b1;
        step();
        check("ar_first_fp", 32'(gnt0), 32'h1);
        check("ar_first_rr", 32'(gnt1), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
# board_mem_arbiter

Parametrised, clocked arbiter that shares the single-port board memory among NUM_CH requesters (init, validity check, flip, VGA, and future agents). It replaces fixed-priority combinational selection with a registered request/grant handshake, selectable fixed-priority or round-robin policy, bounded hold time with lock override, and a tagged read-return path for the synchronous RAM. It sits between the game-logic engines and the board RAM.

## Interface
Parameters:
- NUM_CH, 4, number of requesting channels (≥2)
- ADDR_W, 7, memory address width
- DATA_W, 2, cell data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- MAX_HOLD, 16, max consecutive granted cycles before preemption (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_CH  per-channel access request, level
- lock  in  NUM_CH  per-channel: owner may not be preempted while high
- addr_in  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- data_in  in  NUM_CH*DATA_W  packed write data
- wren_in  in  NUM_CH  per-channel write enable
- mem_q  in  DATA_W  RAM read data, valid one cycle after address
- gnt  out  NUM_CH  one-hot or zero grant, registered
- addr_out  out  ADDR_W  to RAM
- data_out  out  DATA_W  to RAM
- wren_out  out  1  to RAM
- rdata  out  DATA_W  equals mem_q
- rvalid  out  NUM_CH  per-channel read-return strobe, registered
- busy  out  1  gnt != 0

## Operation
- States: IDLE (gnt == 0), OWNED (exactly one gnt bit set). Owner index held in a register.
- IDLE: if any req, choose winner; next edge gnt[winner] = 1, state OWNED, hold_cnt = 1.
- OWNED, req[owner] high, no preemption: gnt unchanged, hold_cnt increments, saturating at MAX_HOLD.
- OWNED, req[owner] low: release. Arbitrate among remaining requests this cycle; next edge gnt = new winner (hold_cnt = 1) or 0 (IDLE). No dead cycle between owners.
- Preemption: hold_cnt == MAX_HOLD, lock[owner] low, and another req pending → next edge grant passes to the winner among non-owner requesters. lock[owner] high inhibits preemption indefinitely.
- Winner selection: RR_MODE=0 uses the lowest set index. RR_MODE=1 uses the first set index strictly after last_winner, with wrap. last_winner updates on every new grant.
- Bus mux, combinational from registered owner: addr_out = addr_in[owner], data_out = data_in[owner], wren_out = wren_in[owner] & req[owner] & gnt[owner]. With no grant, all outputs are 0. Outputs never latch.
- Read return: a cycle with gnt[i] & req[i] & ~wren_in[i] is a read. rvalid[i] pulses high on the following cycle, and rdata carries mem_q.

## Timing
- Arbitration latency: req rising sampled at edge k gives gnt at edge k; the first bus access is cycle k..k+1. Minimum 1 cycle from request to grant.
- Owner sees gnt and may drive a new address every cycle: one access per cycle, writes committed at the RAM edge.
- Read latency: 1 cycle from the access cycle to rvalid/rdata.
- Reset values: gnt = 0, owner = 0, hold_cnt = 0, last_winner = NUM_CH-1 (channel 0 first in RR), rvalid = 0. Combinational outputs: addr_out = 0, data_out = 0, wren_out = 0, busy = 0.
- Reset asserted mid-access: gnt clears asynchronously, so wren_out drops immediately. Pending rvalid is discarded.
- Simultaneous release and new request from the releasing channel: the releasing channel's req is low, so it is not eligible that cycle.
- Owner deasserting req during the preemption cycle: treated as a normal release.

## Structure
- Shared package board_mem_pkg holds ADDR_W=7, DATA_W=2, and channel index constants CH_INIT=0, CH_VALI=1, CH_FLIP=2, CH_VGA=3. It is also used by the top level for packing.
- Sub-module rr_pick (NUM_CH): inputs are the request vector, base index and mode. Outputs are the one-hot winner and the any-valid flag. It is instantiated once and shared by the release and preemption paths.

## Test plan
- Reset, then req = 4'b1010 with RR_MODE=0 → gnt = 4'b0010 one edge later. addr_out = addr_in[1]. wren_out = 0 while gnt = 0.
- RR_MODE=1, req = 4'b1111 held, each owner releases after 1 cycle → grant order 0,1,2,3,0.
- Channel 2 holds req, ch0 requesting, MAX_HOLD=4, lock[2]=0 → gnt moves to ch0 after 4 granted cycles. Repeat with lock[2]=1 → ch2 keeps the grant 20+ cycles.
- Channel 3 reads addr 7'h25, then addr 7'h26 back-to-back → rvalid[3] high for 2 cycles, one cycle delayed, with rdata equal to the RAM contents.
- Owner ch1 drops req while ch3 requests → gnt goes 4'b0010 → 4'b1000 at the next edge with no zero cycle.
- rst_n pulsed low mid-write → wren_out = 0 asynchronously, all registers at reset values, and the first grant after release goes to ch0.
